// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter and
// other shared-port arbiters built from rr_arbiter.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // Register index that is hardwired to zero in the register file.
  localparam int REG_ZERO = 0;

  // LSB position of field idx in a vector packed as idx*w +: w.
  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr,
// wrapping modulo NUM_REQ, gives a one-hot grant plus its encoded index.
module regfile_wb_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int c;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    c         = 0;
    cand      = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = int'(ptr) + k;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        cand = IDX_W'(c);
        if (!grant_any && valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources through
// a round-robin grant feeding one registered output stage.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wb_hold,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic [ADDR_W-1:0]         query_reg,
  output logic                      query_hit,
  output logic [CNT_W-1:0]          write_count
);

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int REG_LSB_W  = $clog2(NUM_REQ * ADDR_W);
  localparam int DATA_LSB_W = $clog2(NUM_REQ * DATA_W);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  // Gating with reset_n keeps ready low for the whole time reset is asserted,
  // not just from the first edge.
  regfile_wb_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .enable    (!wb_hold && reset_n),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (handshake)
  );

  assign req_ready = grant;

  assign sel_reg  = req_reg[REG_LSB_W'(slice_lsb(int'(grant_idx), ADDR_W)) +: ADDR_W];
  assign sel_data = req_data[DATA_LSB_W'(slice_lsb(int'(grant_idx), DATA_W)) +: DATA_W];

  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      write_count   <= '0;
    end else if (!wb_hold) begin
      if (handshake) begin
        rr_ptr        <= ptr_next;
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
        // r0 writes complete the handshake but are never enabled toward the file.
        rf_reg_write  <= (sel_reg != ZERO_IDX);
        write_count   <= write_count + CNT_W'(1);
      end else begin
        rf_reg_write  <= 1'b0;
      end
    end
  end

  assign query_hit = rf_reg_write && (rf_write_reg == query_reg) && (query_reg != ZERO_IDX);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a plain register-file model that
// commits the output stage one edge after it is presented.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        wb_hold;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [4:0]  query_reg;
  logic        query_hit;
  logic [15:0] write_count;

  int errors;
  int checks;
  logic [31:0] rf_model [32];

  regfile_wb_arbiter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .wb_hold       (wb_hold),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .query_reg     (query_reg),
    .query_hit     (query_hit),
    .write_count   (write_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file with no special r0 handling, so any enabled r0 write shows.
  always @(posedge clock) begin
    if (rf_reg_write) rf_model[rf_write_reg] <= rf_write_data;
  end

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[i*5 +: 5]   = r;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    req_valid = 3'b111;
    tick();
    tick();
    checks++;
    if (write_count !== 16'd2) begin
      errors++; $display("FAIL reset_prerun_count got=%0d exp=2", write_count);
    end
    checks++;
    if (rf_write_reg !== 5'd2) begin
      errors++; $display("FAIL reset_prerun_reg got=%0d exp=2", rf_write_reg);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b exp=000", req_ready);
    end
    checks++;
    if ({rf_reg_write, rf_write_reg, rf_write_data, write_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b reg=%0d data=%h cnt=%0d exp all 0",
               rf_reg_write, rf_write_reg, rf_write_data, write_count);
    end
    req_valid = 3'b000;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready got=%b exp=010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    checks++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd7 || rf_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_output got we=%b reg=%0d data=%h exp we=1 reg=7 data=deadbeef",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    checks++;
    if (write_count !== 16'd1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", write_count);
    end
    tick();
    checks++;
    if (rf_model[7] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_readback got=%h exp=deadbeef", rf_model[7]);
    end
    checks++;
    if (rf_reg_write !== 1'b0) begin
      errors++; $display("FAIL single_idle_we got=%b exp=0", rf_reg_write);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h200);
    set_req(2, 5'd3, 32'h300);
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'(1 << (i % 3));
      #1;
      checks++;
      if (req_ready !== exp_g) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_g);
      end
      tick();
      checks++;
      if (rf_write_reg !== 5'((i % 3) + 1) || rf_write_data !== 32'((i % 3 + 1) * 256)) begin
        errors++;
        $display("FAIL rr_output%0d got reg=%0d data=%h exp reg=%0d", i,
                 rf_write_reg, rf_write_data, (i % 3) + 1);
      end
    end
    req_valid = 3'b000;
    checks++;
    if (write_count !== 16'd4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", write_count);
    end
  endtask

  task automatic test_r0_write();
    set_req(0, 5'd0, 32'd5);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL r0_ready got=%b exp=001", req_ready);
    end
    tick();
    req_valid = 3'b000;
    checks++;
    if (rf_reg_write !== 1'b0) begin
      errors++; $display("FAIL r0_we got=%b exp=0", rf_reg_write);
    end
    checks++;
    if (write_count !== 16'd5) begin
      errors++; $display("FAIL r0_count got=%0d exp=5", write_count);
    end
    checks++;
    if (rf_write_reg !== 5'd0 || rf_write_data !== 32'd5) begin
      errors++; $display("FAIL r0_capture got reg=%0d data=%h exp reg=0 data=5",
                         rf_write_reg, rf_write_data);
    end
    tick();
    checks++;
    if (rf_model[0] !== 32'd0) begin
      errors++; $display("FAIL r0_readback got=%h exp=0", rf_model[0]);
    end
  endtask

  task automatic test_hold();
    set_req(1, 5'd9, 32'h99);
    req_valid = 3'b010;
    tick();
    wb_hold = 1'b1;
    set_req(1, 5'd4, 32'h44);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL hold_ready_entry got=%b exp=000", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (req_ready !== 3'b000 || rf_reg_write !== 1'b1 || rf_write_reg !== 5'd9 ||
          rf_write_data !== 32'h99 || write_count !== 16'd6) begin
        errors++;
        $display("FAIL hold_frozen%0d got rdy=%b we=%b reg=%0d data=%h cnt=%0d exp rdy=000 we=1 reg=9 data=99 cnt=6",
                 i, req_ready, rf_reg_write, rf_write_reg, rf_write_data, write_count);
      end
    end
    wb_hold = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL hold_release_ready got=%b exp=010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    checks++;
    if (rf_write_reg !== 5'd4 || rf_write_data !== 32'h44 || write_count !== 16'd7) begin
      errors++; $display("FAIL hold_release_out got reg=%0d data=%h cnt=%0d exp reg=4 data=44 cnt=7",
                         rf_write_reg, rf_write_data, write_count);
    end
  endtask

  task automatic test_query();
    set_req(2, 5'd9, 32'h9);
    req_valid = 3'b100;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL query_ready got=%b exp=100", req_ready);
    end
    tick();
    req_valid = 3'b000;
    wb_hold   = 1'b1;
    query_reg = 5'd9;
    #1;
    checks++;
    if (query_hit !== 1'b1) begin
      errors++; $display("FAIL query_hit9 got=%b exp=1", query_hit);
    end
    query_reg = 5'd0;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++; $display("FAIL query_hit0 got=%b exp=0", query_hit);
    end
    query_reg = 5'd8;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++; $display("FAIL query_hit8 got=%b exp=0", query_hit);
    end
    wb_hold   = 1'b0;
    query_reg = 5'd9;
    tick();
    checks++;
    if (query_hit !== 1'b0) begin
      errors++; $display("FAIL query_idle got=%b exp=0", query_hit);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    wb_hold   = 1'b0;
    query_reg = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    #2;
    test_reset();
    test_single_write();
    test_round_robin();
    test_r0_write();
    test_hold();
    test_query();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
